packet_arbiter_rr: RTL and testbench
====================================

# packet_arbiter_rr

Per-output-port packet arbiter for the AXI-Stream NoC router. It collects the per-direction `out_mosi_o` requests that each input's routing stage produces for one output channel. It grants exactly one input at a time in round-robin order and holds that grant from the routing-header beat through the TLAST handshake, so packets never interleave on a link. The router instantiates one per output channel, between the routing stages and the output register/link.

## Interface
- `CHANNEL_NUMBER`, 5, number of competing inputs (local + 4 mesh directions)
- `CHANNEL_NUMBER_WIDTH`, `$clog2(CHANNEL_NUMBER)`, grant index width
- `STATS_WIDTH`, 16, width of per-input packet counters (used only with the config macro)

Ports:
- `clk_i`  in  1  clock, single clock domain
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `in_mosi_i`  in  `axis_mosi_t [CHANNEL_NUMBER]`  requests from each input's routing stage
- `in_miso_o`  out  `axis_miso_t [CHANNEL_NUMBER]`  backpressure to each input
- `out_mosi_o`  out  `axis_mosi_t`  arbitrated stream toward the output link
- `out_miso_i`  in  `axis_miso_t`  backpressure from the output link
- `grant_valid_o`  out  1  a packet currently owns the output
- `grant_idx_o`  out  `CHANNEL_NUMBER_WIDTH`  index of the owning input
- `pkt_count_o`  out  `STATS_WIDTH [CHANNEL_NUMBER]`  present only with `PACKET_ARBITER_STATS_EN`

## Operation
- The FSM has two states, IDLE and LOCKED. Reset state is IDLE, with `rr_ptr` = 0 and `grant_idx` = 0.
- **IDLE:**
  - A request is any input with TVALID=1 and `data.TID == ROUTING_HEADER`.
  - The winner is the first requester found scanning `rr_ptr`, `rr_ptr+1`, … modulo `CHANNEL_NUMBER`.
  - The winner index is registered and the FSM moves to LOCKED.
  - `out_mosi_o` = '0 and all `in_miso_o` = '0; no beat is accepted in IDLE.
  - Inputs presenting TVALID with a non-header TID are not requests and are stalled.
- **LOCKED:**
  - `out_mosi_o` = `in_mosi_i[grant_idx]` and `in_miso_o[grant_idx]` = `out_miso_i`. All other `in_miso_o` = '0.
  - On TVALID & TREADY & TLAST of the granted input: next state IDLE, `rr_ptr` = `grant_idx`+1, wrapping `CHANNEL_NUMBER`-1 → 0.
  - A header beat that also carries TLAST (single-beat packet) releases on that same handshake.
  - TVALID dropping mid-packet does not release the grant.
- `grant_valid_o` = (state == LOCKED) and `grant_idx_o` = `grant_idx`.
- Modulo arithmetic is explicit compare-and-wrap, never a power-of-two truncation, because `CHANNEL_NUMBER` = 5.

## Timing
- Arbitration latency is 1 cycle: a header presented in cycle N in IDLE is forwarded in cycle N+1 at the earliest.
- After a release, the next grant decision is made in the following IDLE cycle. This gives one bubble cycle between packets.
- Data and ready paths are combinational in LOCKED: zero added latency per beat, with full throughput inside a packet.
- Reset values:
  - `out_mosi_o` = '0 and every `in_miso_o` = '0
  - `grant_valid_o` = 0 and `grant_idx_o` = 0
  - `pkt_count_o` = 0
- Reset asserted mid-packet aborts the grant immediately (asynchronous). The FSM returns to IDLE with `rr_ptr` = 0, and the remaining beats are later treated as non-header and stalled.
- If several requesters are present at once, exactly one is granted; the others hold TVALID with TREADY=0.

## Configuration
- `PACKET_ARBITER_STATS_EN` defined:
  - Per-input `pkt_count_o[i]` increments by 1 on each release (TLAST handshake) by input i.
  - Counters saturate at all-ones and reset to 0.
- Not defined: the `pkt_count_o` port and the counters are absent; behaviour is otherwise identical.

## Structure
- `axis_mosi_t`, `axis_miso_t`, `ROUTING_HEADER` come from the shared router types (`axis_type.svh` / package).
- The state enum `arb_state_t {ARB_IDLE, ARB_LOCKED}` is added to the shared router package.
- One sub-module, `rr_priority_picker`: combinational round-robin first-one search.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: `found` and winner index.
  - Reusable by other router arbiters.

## Test plan
- **Single request:** input 2 sends header + 3 beats (last with TLAST), TREADY=1 → cycle 0 no accept; cycles 1–4 pass through; `grant_idx_o`=2; back to IDLE; `rr_ptr`=3.
- **Contention:** inputs 0, 1 and 4 request simultaneously after reset → grant order 0, 1, 4, each packet contiguous. Loser TREADY stays 0 until granted.
- **Wrap:** `rr_ptr`=4 with requesters 4 and 0 → 4 is granted; after release `rr_ptr`=0 and 0 is granted next.
- **Backpressure:** granted packet with `out_miso_i.TREADY` toggling 1,0,1,0 → beats accepted only on TREADY=1; no data loss or duplication; the grant holds through the stalls.
- **Single-beat packet:** header with TLAST on input 3 → released the cycle it is accepted; IDLE next cycle; `pkt_count_o[3]`=1 with the macro defined.
- **Reset mid-packet:** `rst_n_i` low during beat 2 of 4 → outputs '0 immediately. After reset, the stray data beats (non-header TID) are stalled and not forwarded.

Source files
------------

// File: rtl/packet_arbiter_rr_pkg.sv
// Shared router types for the per-output packet arbiter: AXI-Stream
// request/response structs, TID codes and the arbiter state enum.
package packet_arbiter_rr_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 32;
  localparam int unsigned AXIS_ID_WIDTH   = 2;

  typedef logic [AXIS_ID_WIDTH-1:0] axis_tid_t;

  // TID marking the first (routing) beat of a packet
  localparam axis_tid_t ROUTING_HEADER  = 2'd1;
  // TID carried by every non-header beat
  localparam axis_tid_t ROUTING_PAYLOAD = 2'd2;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] TDATA;
    axis_tid_t                  TID;
  } axis_data_t;

  typedef struct packed {
    logic       TVALID;
    logic       TLAST;
    axis_data_t data;
  } axis_mosi_t;

  typedef struct packed {
    logic TREADY;
  } axis_miso_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // A beat opens a packet when it is valid and tagged as the routing header
  function automatic logic is_header(input axis_mosi_t beat);
    return beat.TVALID && (beat.data.TID == ROUTING_HEADER);
  endfunction

endpackage

// File: rtl/packet_arbiter_rr_picker.sv
// rr_priority_picker: combinational round-robin first-one search.
// Scans req_i starting at rr_ptr_i, wrapping N-1 -> 0 by compare, and
// returns the first set index. Reusable by any router arbiter.
module rr_priority_picker #(
  parameter int unsigned N = 5,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] rr_ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] cand;

  // Walk N candidates from the pointer; the first requester wins
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = rr_ptr_i;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
      cand = (cand == W'(N - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/packet_arbiter_rr.sv
// packet_arbiter_rr: per-output-channel packet arbiter. Grants one input
// at a time in round-robin order and holds the grant from the routing
// header through the TLAST handshake so packets never interleave.
// Optional: define PACKET_ARBITER_STATS_EN to add saturating per-input
// packet counters on pkt_count_o.
module packet_arbiter_rr
  import packet_arbiter_rr_pkg::*;
#(
  parameter int unsigned CHANNEL_NUMBER       = 5,
  parameter int unsigned CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int unsigned STATS_WIDTH          = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  axis_mosi_t                      in_mosi_i [CHANNEL_NUMBER],
  output axis_miso_t                      in_miso_o [CHANNEL_NUMBER],
  output axis_mosi_t                      out_mosi_o,
  input  axis_miso_t                      out_miso_i,
  output logic                            grant_valid_o,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] grant_idx_o
`ifdef PACKET_ARBITER_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]          pkt_count_o [CHANNEL_NUMBER]
`endif
);

  localparam logic [CHANNEL_NUMBER_WIDTH-1:0] LAST_IDX =
    CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);

  arb_state_t                      state_q, state_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] grant_idx_q, grant_idx_d;
  logic [CHANNEL_NUMBER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CHANNEL_NUMBER-1:0]       req;
  logic                            pick_found;
  logic [CHANNEL_NUMBER_WIDTH-1:0] pick_idx;
  axis_mosi_t                      granted_beat;
  logic                            release_beat;

  // Only header beats compete; stray payload beats are ignored and stalled
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
      req[i] = is_header(in_mosi_i[i]);
    end
  end

  rr_priority_picker #(
    .N (CHANNEL_NUMBER),
    .W (CHANNEL_NUMBER_WIDTH)
  ) u_picker (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx)
  );

  assign granted_beat  = in_mosi_i[grant_idx_q];
  assign release_beat  = (state_q == ARB_LOCKED) && granted_beat.TVALID &&
                         out_miso_i.TREADY && granted_beat.TLAST;
  assign grant_valid_o = (state_q == ARB_LOCKED);
  assign grant_idx_o   = grant_idx_q;

  // Next-state and datapath steering; nothing moves while IDLE
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    out_mosi_o  = '0;
    for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
      in_miso_o[i] = '0;
    end
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          state_d     = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        out_mosi_o = granted_beat;
        for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
          if (grant_idx_q == CHANNEL_NUMBER_WIDTH'(i)) begin
            in_miso_o[i] = out_miso_i;
          end
        end
        if (release_beat) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state registers; reset aborts any grant in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

`ifdef PACKET_ARBITER_STATS_EN
  // Count completed packets per input, saturating at all-ones
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
        pkt_count_o[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNEL_NUMBER; i++) begin
        if (release_beat && (grant_idx_q == CHANNEL_NUMBER_WIDTH'(i)) &&
            (pkt_count_o[i] != '1)) begin
          pkt_count_o[i] <= pkt_count_o[i] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_packet_arbiter_rr.sv
// Bench for packet_arbiter_rr: packet sources per input, a queue-free
// behavioural arbiter model, a per-cycle compare process, directed
// scenarios with literal expectations and a randomized soak.
module tb_packet_arbiter_rr;
  import packet_arbiter_rr_pkg::*;

  localparam int N = 5;
  localparam int W = $clog2(N);

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  axis_mosi_t     in_mosi [N];
  axis_miso_t     in_miso [N];
  axis_mosi_t     out_mosi;
  axis_miso_t     out_miso;
  logic           gv;
  logic [W-1:0]   gi;
`ifdef PACKET_ARBITER_STATS_EN
  logic [15:0]    pkt_count [N];
`endif

  always #5 clk = ~clk;

  packet_arbiter_rr #(
    .CHANNEL_NUMBER       (N),
    .CHANNEL_NUMBER_WIDTH (W),
    .STATS_WIDTH          (16)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .in_mosi_i     (in_mosi),
    .in_miso_o     (in_miso),
    .out_mosi_o    (out_mosi),
    .out_miso_i    (out_miso),
    .grant_valid_o (gv),
    .grant_idx_o   (gi)
`ifdef PACKET_ARBITER_STATS_EN
    ,
    .pkt_count_o   (pkt_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_cnt [N];
  bit m_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked = 0;
      m_owner  = 0;
      m_ptr    = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (!m_locked) begin
      m_hit = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!m_hit && in_mosi[j].TVALID && in_mosi[j].data.TID == ROUTING_HEADER) begin
          m_hit    = 1;
          m_owner  = j;
          m_locked = 1;
        end
      end
    end else if (in_mosi[m_owner].TVALID && out_miso.TREADY && in_mosi[m_owner].TLAST) begin
      m_locked = 0;
      m_ptr    = (m_owner + 1) % N;
      if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
    end
  end

  axis_mosi_t e_out;

  always @(negedge clk) begin
    e_out = m_locked ? in_mosi[m_owner] : '0;
    chk("grant_valid", 64'(gv), 64'(m_locked));
    chk("grant_idx", 64'(gi), 64'(m_owner));
    chk("out_mosi", 64'(out_mosi), 64'(e_out));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("in_miso[%0d]", i), 64'(in_miso[i].TREADY),
          64'((m_locked && m_owner == i) ? out_miso.TREADY : 1'b0));
`ifdef PACKET_ARBITER_STATS_EN
      chk($sformatf("pkt_count[%0d]", i), 64'(pkt_count[i]), 64'(m_cnt[i]));
`endif
    end
  end

  // ---------------- packet sources ----------------
  int len [N];
  int beat [N];
  int pkt [N];
  bit stray [N];
  bit acc [N];
  int acc_cnt [N];
  bit rand_mode  = 0;
  int ready_mode = 0;
  int ready_phase = 0;
  bit s_gv;
  logic [W-1:0] s_gi;
  int order_q [$];

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (len[i] > 0) return 1;
    return 0;
  endfunction

  function automatic int order_at(input int k);
    if (k < order_q.size()) return order_q[k];
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      axis_mosi_t m;
      m = '0;
      if (len[i] > 0) begin
        m.TVALID     = !(rand_mode && beat[i] > 0 && $urandom_range(3) == 0);
        m.data.TDATA = {8'(i), 8'(pkt[i]), 16'(beat[i])};
        m.data.TID   = (beat[i] == 0) ? ROUTING_HEADER : ROUTING_PAYLOAD;
        m.TLAST      = (beat[i] == len[i] - 1);
      end else if (stray[i]) begin
        m.TVALID     = 1'b1;
        m.data.TDATA = 32'hDEAD_0000 | 32'(i);
        m.data.TID   = ROUTING_PAYLOAD;
      end
      in_mosi[i] = m;
    end
    case (ready_mode)
      0: out_miso.TREADY = 1'b1;
      1: begin
        out_miso.TREADY = (ready_phase % 2 == 0);
        ready_phase++;
      end
      default: out_miso.TREADY = ($urandom_range(3) != 0);
    endcase
  endtask

  // One clock: present, sample mid-cycle, then advance after the edge
  task automatic tick();
    drive();
    @(negedge clk);
    s_gv = gv;
    s_gi = gi;
    for (int i = 0; i < N; i++) acc[i] = in_mosi[i].TVALID && in_miso[i].TREADY;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      stray[i] = 0;
      if (acc[i]) begin
        beat[i]++;
        if (beat[i] == len[i]) begin
          len[i]  = 0;
          beat[i] = 0;
          pkt[i]++;
        end
      end
      if (rand_mode && len[i] == 0) begin
        if ($urandom_range(3) == 0) len[i] = $urandom_range(5, 1);
        else if ($urandom_range(15) == 0) stray[i] = 1;
      end
    end
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int n;
    bit prev;
    n = 0;
    prev = 0;
    order_q.delete();
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    do begin
      tick();
      n++;
      for (int i = 0; i < N; i++) if (acc[i]) acc_cnt[i]++;
      if (s_gv && !prev) order_q.push_back(int'(s_gi));
      prev = s_gv;
    end while ((busy() || s_gv) && n < budget);
    chk({name, "_idle"}, 64'(busy() || s_gv), 64'(0));
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      len[i] = 0; beat[i] = 0; stray[i] = 0;
    end
    drive();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int before3;

  initial begin
    for (int i = 0; i < N; i++) begin
      len[i] = 0; beat[i] = 0; pkt[i] = 0; stray[i] = 0;
    end
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gv", 64'(gv), 64'(0));
    chk("reset_gi", 64'(gi), 64'(0));
    chk("reset_out", 64'(out_mosi), 64'(0));
    for (int i = 0; i < N; i++) chk("reset_in_miso", 64'(in_miso[i].TREADY), 64'(0));
    rst_n = 1'b1;

    // single request on input 2: header + 3 beats
    len[2] = 4;
    tick();
    chk("single_c0_acc", 64'(acc[2]), 64'(0));
    chk("single_c0_gv", 64'(s_gv), 64'(0));
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("single_acc", 64'(acc[2]), 64'(1));
      chk("single_gi", 64'(s_gi), 64'(2));
    end
    tick();
    chk("single_idle", 64'(s_gv), 64'(0));
    chk("single_ptr", 64'(m_ptr), 64'(3));

    // contention after reset: 0, 1, 4
    do_reset();
    len[0] = 2; len[1] = 2; len[4] = 2;
    run_until_idle(40, "contention");
    chk("cont_n", 64'(order_q.size()), 64'(3));
    chk("cont_0", 64'(order_at(0)), 64'(0));
    chk("cont_1", 64'(order_at(1)), 64'(1));
    chk("cont_2", 64'(order_at(2)), 64'(4));

    // wrap: move pointer to 4, then 4 and 0 compete
    len[3] = 1;
    run_until_idle(10, "wrap_setup");
    chk("wrap_ptr4", 64'(m_ptr), 64'(4));
    len[4] = 2; len[0] = 2;
    run_until_idle(30, "wrap");
    chk("wrap_0", 64'(order_at(0)), 64'(4));
    chk("wrap_1", 64'(order_at(1)), 64'(0));
    chk("wrap_ptr1", 64'(m_ptr), 64'(1));

    // backpressure: TREADY toggles 1,0,1,0
    ready_mode = 1;
    ready_phase = 0;
    len[1] = 4;
    run_until_idle(40, "bp");
    chk("bp_beats", 64'(acc_cnt[1]), 64'(4));
    chk("bp_grants", 64'(order_q.size()), 64'(1));
    chk("bp_idx", 64'(order_at(0)), 64'(1));
    ready_mode = 0;

    // single-beat packet on input 3
    do_reset();
    len[3] = 1;
    tick();
    chk("sb_c0_acc", 64'(acc[3]), 64'(0));
    chk("sb_c0_gv", 64'(s_gv), 64'(0));
    tick();
    chk("sb_acc", 64'(acc[3]), 64'(1));
    chk("sb_gi", 64'(s_gi), 64'(3));
    tick();
    chk("sb_idle", 64'(s_gv), 64'(0));
`ifdef PACKET_ARBITER_STATS_EN
    before3 = int'(pkt_count[3]);
    chk("sb_count", 64'(before3), 64'(1));
`endif

    // reset in the middle of a 4-beat packet on input 2
    len[2] = 4;
    tick();
    tick();
    tick();
    chk("rst_beat_idx", 64'(beat[2]), 64'(2));
    drive();
    #2;
    chk("rst_pre_gv", 64'(gv), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_out", 64'(out_mosi), 64'(0));
    chk("rst_gv", 64'(gv), 64'(0));
    chk("rst_gi", 64'(gi), 64'(0));
    chk("rst_ready", 64'(in_miso[2].TREADY), 64'(0));
    @(posedge clk);
    #1;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("stray_acc", 64'(acc[2]), 64'(0));
      chk("stray_gv", 64'(s_gv), 64'(0));
    end
    len[2] = 0; beat[2] = 0; pkt[2]++;
    tick();

    // randomized soak
    rand_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) ready_mode = $urandom_range(2);
      tick();
    end
    rand_mode = 0;
    ready_mode = 0;
    run_until_idle(200, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
